// File: rtl/reg_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter_if
// Groups every signal exchanged between reg_bus_arbiter and its environment:
// the two requester ports (m0_*, m1_*), the shared response (rsp_*) and the
// register-file bus (bus_*).
//   modport master : arbiter view (samples requests/bus read side, drives
//                    grants, completions, responses and bus strobes)
//   modport slave  : environment view (requesters plus register file)
// ADDR_W / DATA_W must match the parameters of the arbiter instance.
// -----------------------------------------------------------------------------
interface reg_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    // requester 0
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_done;
    // requester 1
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_done;
    // shared response, qualified by m0_done / m1_done
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // register-file bus
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_cs;
    logic              bus_we;
    logic              bus_re;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_valid;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  bus_rdata, bus_valid,
        output m0_gnt, m0_done, m1_gnt, m1_done,
        output rsp_rdata, rsp_err,
        output bus_addr, bus_cs, bus_we, bus_re, bus_wdata
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output bus_rdata, bus_valid,
        input  m0_gnt, m0_done, m1_gnt, m1_done,
        input  rsp_rdata, rsp_err,
        input  bus_addr, bus_cs, bus_we, bus_re, bus_wdata
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter
// Two-requester round-robin arbiter and sequencer for the register-file bus.
// One transaction is in flight at a time: the winner's request is latched,
// the bus strobes are driven for exactly one cycle, read data is captured,
// the registered data_valid is awaited (bounded by TIMEOUT cycles) and the
// result is returned to the owning requester with a one-cycle done pulse.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : reg_bus_arbiter_if.master
//          m0_*/m1_* req/we/addr/wdata in, gnt/done out
//          rsp_rdata/rsp_err out (valid while a done pulse is high)
//          bus_addr/cs/we/re/wdata out, bus_rdata/bus_valid in
//
// All outputs come straight from flops; each output flop's next value is
// computed from the current state, so an output seen in cycle n reflects the
// decision taken at the edge that ended cycle n-1.
// -----------------------------------------------------------------------------
module reg_bus_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst,
    reg_bus_arbiter_if.master   bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD      = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;  // 0 = m0, 1 = m1
    logic               owner_q, owner_d;            // 0 = m0, 1 = m1
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  cap_q, cap_d;                // read data captured in RD
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic               bus_cs_q, bus_cs_d;
    logic               bus_we_q, bus_we_d;
    logic               bus_re_q, bus_re_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    // arbitration helpers
    logic               any_req_s;
    logic               win_s;
    logic               win_we_s;
    logic [ADDR_W-1:0]  win_addr_s;
    logic [DATA_W-1:0]  win_wdata_s;

    // Winner selection: a lone requester wins; on a tie the requester that
    // was not granted last time wins.
    always_comb begin
        any_req_s = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            win_s = ~last_grant_q;
        end else if (bus.m1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (win_s) begin
            win_we_s    = bus.m1_we;
            win_addr_s  = bus.m1_addr;
            win_wdata_s = bus.m1_wdata;
        end else begin
            win_we_s    = bus.m0_we;
            win_addr_s  = bus.m0_addr;
            win_wdata_s = bus.m0_wdata;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            cap_q        <= {DATA_W{1'b0}};
            bus_addr_q   <= {ADDR_W{1'b0}};
            bus_wdata_q  <= {DATA_W{1'b0}};
            bus_cs_q     <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_re_q     <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rsp_rdata_q  <= {DATA_W{1'b0}};
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_cs_q     <= bus_cs_d;
            bus_we_q     <= bus_we_d;
            bus_re_q     <= bus_re_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    state_d = win_we_s ? S_WR : S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR:      state_d = S_RESP;
            S_RD:      state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                // bus_valid is only meaningful here; elsewhere it is ignored
                if (bus.bus_valid || (cnt_q == CNT_LAST)) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values: pulses default low, data registers hold.
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        cap_d        = cap_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_cs_d     = 1'b0;
        bus_we_d     = 1'b0;
        bus_re_d     = 1'b0;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    // strobes are raised here so they appear in the WR/RD cycle
                    bus_addr_d   = win_addr_s;
                    bus_wdata_d  = win_wdata_s;
                    owner_d      = win_s;
                    last_grant_d = win_s;
                    gnt0_d       = ~win_s;
                    gnt1_d       = win_s;
                    bus_cs_d     = 1'b1;
                    bus_we_d     = win_we_s;
                    bus_re_d     = ~win_we_s;
                end else begin
                    bus_cs_d     = 1'b0;
                end
            end
            S_WR: begin
                done0_d     = ~owner_q;
                done1_d     = owner_q;
                rsp_rdata_d = {DATA_W{1'b0}};
                rsp_err_d   = 1'b0;
            end
            S_RD: begin
                // bus_rdata is only valid during the strobe cycle
                cap_d = bus.bus_rdata;
                cnt_d = {CNT_W{1'b0}};
            end
            S_RD_WAIT: begin
                if (bus.bus_valid) begin
                    done0_d     = ~owner_q;
                    done1_d     = owner_q;
                    rsp_rdata_d = cap_q;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    done0_d     = ~owner_q;
                    done1_d     = owner_q;
                    rsp_rdata_d = {DATA_W{1'b0}};
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    assign bus.m0_gnt    = gnt0_q;
    assign bus.m1_gnt    = gnt1_q;
    assign bus.m0_done   = done0_q;
    assign bus.m1_done   = done1_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_cs    = bus_cs_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_re    = bus_re_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_arbiter
// Scoreboard bench for reg_bus_arbiter. Stimulus batches give each requester
// a list of transactions; a transaction-level model predicts grant order,
// bus strobes and responses into queues, and a monitor on the falling edge
// pops and compares whenever the DUT presents a grant, strobe or done.
// -----------------------------------------------------------------------------
module tb_reg_bus_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct packed {
        logic          owner;
        logic [DW-1:0] rdata;
        logic          err;
        logic [7:0]    lat;   // cycles from grant to done
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // requester drive
    logic          m_req   [2];
    logic          m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    assign bif.m0_req   = m_req[0];
    assign bif.m0_we    = m_we[0];
    assign bif.m0_addr  = m_addr[0];
    assign bif.m0_wdata = m_wdata[0];
    assign bif.m1_req   = m_req[1];
    assign bif.m1_we    = m_we[1];
    assign bif.m1_addr  = m_addr[1];
    assign bif.m1_wdata = m_wdata[1];

    // register-file responder
    logic [DW-1:0] rf_mem [256];
    logic mute = 1'b0;
    logic stray_idle = 1'b0;
    logic stray_wr_en = 1'b0;
    logic valid_q = 1'b0;
    always @(posedge clk) begin
        valid_q <= bif.bus_cs & bif.bus_re & ~mute;
        if (bif.bus_cs && bif.bus_we) rf_mem[bif.bus_addr] <= bif.bus_wdata;
    end
    assign bif.bus_rdata = (bif.bus_cs && bif.bus_re) ? rf_mem[bif.bus_addr] : 32'hDEAD_BEEF;
    assign bif.bus_valid = valid_q | stray_idle | (stray_wr_en & bif.bus_cs & bif.bus_we);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] model_mem [256];
    logic model_last = 1'b1;
    logic exp_gnt_q [$];
    txn_t exp_str_q [$];
    rsp_t exp_rsp_q [$];
    txn_t txq0 [$];
    txn_t txq1 [$];
    int   gnt_cyc [2];
    int   first_gnt_exp = 0;
    logic first_pending = 1'b0;
    logic prev_cs = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic gnt_of(input int i);
        return (i == 0) ? bif.m0_gnt : bif.m1_gnt;
    endfunction

    // Monitor: compares every grant, strobe and done against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bif.m0_gnt || bif.m1_gnt) begin
                    check("gnt_both", {63'd0, bif.m0_gnt & bif.m1_gnt}, 64'd0);
                    if (exp_gnt_q.size() == 0) fail_now("gnt_unexpected");
                    else check("gnt_owner", {63'd0, bif.m1_gnt}, {63'd0, exp_gnt_q.pop_front()});
                    check("gnt_with_strobe", {63'd0, bif.bus_cs}, 64'd1);
                    if (first_pending) begin
                        check("gnt_latency", cyc, first_gnt_exp);
                        first_pending = 1'b0;
                    end
                    gnt_cyc[bif.m1_gnt ? 1 : 0] = cyc;
                end
                if (bif.bus_cs) begin
                    txn_t t;
                    check("strobe_back_to_back", {63'd0, prev_cs}, 64'd0);
                    check("strobe_kind", {63'd0, bif.bus_we ^ bif.bus_re}, 64'd1);
                    if (exp_str_q.size() == 0) fail_now("strobe_unexpected");
                    else begin
                        t = exp_str_q.pop_front();
                        check("strobe_we", {63'd0, bif.bus_we}, {63'd0, t.we});
                        check("strobe_addr", bif.bus_addr, t.addr);
                        if (t.we) check("strobe_wdata", bif.bus_wdata, t.wdata);
                    end
                end else begin
                    check("no_strobe_we_re", {63'd0, bif.bus_we | bif.bus_re}, 64'd0);
                end
                prev_cs = bif.bus_cs;
                if (bif.m0_done || bif.m1_done) begin
                    rsp_t r;
                    logic o;
                    o = bif.m1_done;
                    check("done_both", {63'd0, bif.m0_done & bif.m1_done}, 64'd0);
                    if (exp_rsp_q.size() == 0) fail_now("done_unexpected");
                    else begin
                        r = exp_rsp_q.pop_front();
                        check("done_owner", {63'd0, o}, {63'd0, r.owner});
                        check("rsp_rdata", bif.rsp_rdata, r.rdata);
                        check("rsp_err", {63'd0, bif.rsp_err}, {63'd0, r.err});
                        check("done_latency", cyc - gnt_cyc[o ? 1 : 0], {56'd0, r.lat});
                    end
                end
            end else begin
                prev_cs = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {56'd0, bif.m0_gnt, bif.m1_gnt, bif.m0_done, bif.m1_done,
                               bif.bus_cs, bif.bus_we, bif.bus_re, bif.rsp_err}, 64'd0);
        check({tag, "_rdata"}, bif.rsp_rdata, 64'd0);
        check({tag, "_addr"}, bif.bus_addr, 64'd0);
        check({tag, "_wdata"}, bif.bus_wdata, 64'd0);
    endtask

    // Requester i: present each queued transaction and hold req until granted.
    task automatic drive(input int i);
        txn_t t;
        int   n;
        forever begin
            if (i == 0) begin
                if (txq0.size() == 0) break;
                t = txq0.pop_front();
            end else begin
                if (txq1.size() == 0) break;
                t = txq1.pop_front();
            end
            m_we[i] = t.we;
            m_addr[i] = t.addr;
            m_wdata[i] = t.wdata;
            m_req[i] = 1'b1;
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                n++;
                if (gnt_of(i)) break;
            end
            if (!gnt_of(i)) fail_now(i == 0 ? "gnt_timeout_m0" : "gnt_timeout_m1");
        end
        // after grant the inputs are free to change
        m_req[i] = 1'b0;
        m_we[i] = 1'($urandom);
        m_addr[i] = AW'($urandom);
        m_wdata[i] = $urandom;
    endtask

    // Predict the whole batch at transaction level, then run it.
    task automatic predict();
        int   a = 0;
        int   b = 0;
        int   n0 = txq0.size();
        int   n1 = txq1.size();
        logic w;
        txn_t t;
        rsp_t r;
        while (a < n0 || b < n1) begin
            if (a < n0 && b < n1) w = ~model_last;
            else w = (a < n0) ? 1'b0 : 1'b1;
            if (w == 1'b0) begin t = txq0[a]; a++; end
            else begin t = txq1[b]; b++; end
            model_last = w;
            exp_gnt_q.push_back(w);
            exp_str_q.push_back(t);
            r.owner = w;
            if (t.we) begin
                model_mem[t.addr] = t.wdata;
                r.rdata = '0; r.err = 1'b0; r.lat = 8'd1;
            end else if (mute) begin
                r.rdata = '0; r.err = 1'b1; r.lat = 8'(TO + 1);
            end else begin
                r.rdata = model_mem[t.addr]; r.err = 1'b0; r.lat = 8'd2;
            end
            exp_rsp_q.push_back(r);
        end
    endtask

    task automatic run_batch();
        int n = 0;
        predict();
        first_gnt_exp = cyc + 1;
        first_pending = 1'b1;
        fork
            drive(0);
            drive(1);
        join
        while (exp_rsp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_rsp_q.size() > 0) begin
            fail_now("done_timeout");
            exp_rsp_q.delete();
            exp_str_q.delete();
            exp_gnt_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        for (int i = 0; i < 256; i++) begin
            rf_mem[i] = '0;
            model_mem[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
            gnt_cyc[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // single write, then read back from the other requester
        txq0.push_back('{1'b1, 8'h04, 32'hA5A5_0001});
        run_batch();
        txq1.push_back('{1'b0, 8'h04, 32'h0});
        run_batch();

        // contention: both hold req for two transactions each
        txq0.push_back('{1'b1, 8'h10, 32'h1234_5678});
        txq0.push_back('{1'b1, 8'h11, 32'h0BAD_F00D});
        txq1.push_back('{1'b0, 8'h10, 32'h0});
        txq1.push_back('{1'b0, 8'h11, 32'h0});
        run_batch();

        // stray valid while idle and during a write
        stray_idle = 1'b1;
        @(negedge clk);
        stray_idle = 1'b0;
        repeat (3) @(negedge clk);
        stray_wr_en = 1'b1;
        txq1.push_back('{1'b1, 8'h20, 32'hCAFE_0020});
        run_batch();
        stray_wr_en = 1'b0;

        // read timeout, then a normal read
        mute = 1'b1;
        txq0.push_back('{1'b0, 8'h04, 32'h0});
        run_batch();
        mute = 1'b0;
        txq0.push_back('{1'b0, 8'h20, 32'h0});
        run_batch();

        // reset while waiting for read data
        mute = 1'b1;
        t = '{1'b0, 8'h10, 32'h0};
        exp_gnt_q.push_back(1'b0);
        exp_str_q.push_back(t);
        first_gnt_exp = cyc + 1;
        first_pending = 1'b1;
        txq0.push_back(t);
        drive(0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        model_last = 1'b1;
        mute = 1'b0;
        repeat (TO + 4) @(negedge clk);
        txq0.push_back('{1'b1, 8'h30, 32'h3030_3030});
        txq1.push_back('{1'b1, 8'h31, 32'h3131_3131});
        run_batch();

        // randomized batches
        for (int k = 0; k < 40; k++) begin
            int n0;
            int n1;
            mute = ($urandom_range(0, 4) == 0);
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int j = 0; j < n0; j++)
                txq0.push_back('{1'($urandom), 8'($urandom_range(0, 7)), $urandom});
            for (int j = 0; j < n1; j++)
                txq1.push_back('{1'($urandom), 8'($urandom_range(0, 7)), $urandom});
            run_batch();
        end
        mute = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
